// File: rtl/jogo_controle_vidas_if.sv
// Signal bundle between the game controller and the rest of the game.
// The slave side is the controller; the master side drives its inputs.
interface jogo_controle_vidas_if #(
  parameter int PONTOS_W = 8
);
  logic                iniciar;
  logic                press_enter;
  logic                nota_feita;
  logic                nota_correta;
  logic                tempo_correto;
  logic                endereco_igual_rodada;
  logic                fim_rodadas;
  logic                fim_musica;
  logic                fim_mostra;
  logic [1:0]          opcao_erro;

  logic                zeraC;
  logic                contaC;
  logic                zeraCR;
  logic                contaCR;
  logic                registraR;
  logic                leds_mem;
  logic                toca;
  logic                vez_jogador;
  logic                menu_erro;
  logic                ganhou;
  logic                perdeu;
  logic [3:0]          vidas;
  logic [PONTOS_W-1:0] pontos;
  logic [3:0]          db_estado;

  modport master (
    output iniciar, press_enter, nota_feita, nota_correta, tempo_correto,
           endereco_igual_rodada, fim_rodadas, fim_musica, fim_mostra, opcao_erro,
    input  zeraC, contaC, zeraCR, contaCR, registraR, leds_mem, toca,
           vez_jogador, menu_erro, ganhou, perdeu, vidas, pontos, db_estado
  );

  modport slave (
    input  iniciar, press_enter, nota_feita, nota_correta, tempo_correto,
           endereco_igual_rodada, fim_rodadas, fim_musica, fim_mostra, opcao_erro,
    output zeraC, contaC, zeraCR, contaCR, registraR, leds_mem, toca,
           vez_jogador, menu_erro, ganhou, perdeu, vidas, pontos, db_estado
  );
endinterface

// File: rtl/jogo_controle_vidas.sv
// Game control unit: plays back the round, waits for the player's notes,
// tracks lives and score, and runs the error menu. All outputs registered.
module jogo_controle_vidas #(
  parameter int VIDAS    = 3,
  parameter int TIMEOUT  = 50000,
  parameter int PONTOS_W = 8
) (
  input logic                  clock,
  input logic                  reset,
  jogo_controle_vidas_if.slave bus
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    MOSTRA        = 4'h2,
    ESPERA_MOSTRA = 4'h3,
    MOSTRA_PROX   = 4'h4,
    INICIO_NOTA   = 4'h5,
    ESPERA_NOTA   = 4'h6,
    TOCA          = 4'h7,
    COMPARA       = 4'h8,
    PROX_NOTA     = 4'h9,
    PROX_RODADA   = 4'hA,
    ERRO          = 4'hB,
    MENU_ERRO     = 4'hC,
    MOSTRA_ULTIMA = 4'hD,
    GANHOU        = 4'hE,
    FIM           = 4'hF
  } estado_t;

  localparam int                  CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]    CNT_FIM    = CNT_W'(TIMEOUT - 1);
  localparam logic [3:0]          VIDAS_INI  = 4'(VIDAS);
  localparam logic [PONTOS_W-1:0] PONTOS_MAX = '1;

  estado_t             r_estado;
  estado_t             w_prox;
  logic [CNT_W-1:0]    r_cnt;
  logic [3:0]          r_vidas;
  logic [PONTOS_W-1:0] r_pontos;
  logic                r_zeraC, r_contaC, r_zeraCR, r_contaCR, r_registraR;
  logic                r_leds_mem, r_toca, r_vez_jogador, r_menu_erro;
  logic                r_ganhou, r_perdeu;
  logic                w_acerto;

  assign w_acerto = bus.nota_correta & bus.tempo_correto;

  // Next-state decode
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL:       if (bus.iniciar) w_prox = PREPARA;
      PREPARA:       w_prox = MOSTRA;
      MOSTRA:        w_prox = ESPERA_MOSTRA;
      ESPERA_MOSTRA: if (bus.fim_mostra)
                       w_prox = bus.endereco_igual_rodada ? INICIO_NOTA : MOSTRA_PROX;
      MOSTRA_PROX:   w_prox = MOSTRA;
      INICIO_NOTA:   w_prox = ESPERA_NOTA;
      ESPERA_NOTA:   if (bus.nota_feita)          w_prox = TOCA;
                     else if (r_cnt == CNT_FIM)   w_prox = ERRO;
      TOCA:          if (!bus.nota_feita) w_prox = COMPARA;
      COMPARA:       if (!w_acerto)                       w_prox = ERRO;
                     else if (!bus.endereco_igual_rodada) w_prox = PROX_NOTA;
                     else if (bus.fim_rodadas || bus.fim_musica) w_prox = GANHOU;
                     else                                 w_prox = PROX_RODADA;
      PROX_NOTA:     w_prox = ESPERA_NOTA;
      PROX_RODADA:   w_prox = MOSTRA;
      ERRO:          w_prox = (r_vidas == 4'd0) ? FIM : MENU_ERRO;
      MENU_ERRO:     if (bus.press_enter) begin
                       case (bus.opcao_erro)
                         2'b00:   w_prox = MOSTRA;
                         2'b01:   w_prox = INICIO_NOTA;
                         2'b10:   w_prox = MOSTRA_ULTIMA;
                         default: w_prox = FIM;
                       endcase
                     end
      MOSTRA_ULTIMA: if (bus.fim_mostra) w_prox = INICIO_NOTA;
      GANHOU, FIM:   if (bus.iniciar) w_prox = PREPARA;
      default:       w_prox = INICIAL;
    endcase
  end

  // State, counters and registered outputs (decoded from the upcoming state)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado      <= INICIAL;
      r_cnt         <= '0;
      r_vidas       <= VIDAS_INI;
      r_pontos      <= '0;
      r_zeraC       <= 1'b0;
      r_contaC      <= 1'b0;
      r_zeraCR      <= 1'b0;
      r_contaCR     <= 1'b0;
      r_registraR   <= 1'b0;
      r_leds_mem    <= 1'b0;
      r_toca        <= 1'b0;
      r_vez_jogador <= 1'b0;
      r_menu_erro   <= 1'b0;
      r_ganhou      <= 1'b0;
      r_perdeu      <= 1'b0;
    end else begin
      r_estado <= w_prox;

      if (r_estado == ESPERA_NOTA)
        r_cnt <= r_cnt + 1'b1;
      else if (r_estado == INICIO_NOTA || r_estado == PROX_NOTA)
        r_cnt <= '0;

      if (w_prox == PREPARA)
        r_vidas <= VIDAS_INI;
      else if (w_prox == ERRO && r_vidas != 4'd0)
        r_vidas <= r_vidas - 1'b1;
      else if (r_estado == MENU_ERRO && w_prox == FIM)
        r_vidas <= 4'd0;

      if (w_prox == PREPARA)
        r_pontos <= '0;
      else if (r_estado == COMPARA && w_prox != ERRO && r_pontos != PONTOS_MAX)
        r_pontos <= r_pontos + 1'b1;

      // Leaving the menu with "repeat round" clears the note pointer on entry to MOSTRA
      r_zeraC       <= (w_prox == PREPARA) || (w_prox == INICIO_NOTA) ||
                       (w_prox == PROX_RODADA) ||
                       (r_estado == MENU_ERRO && w_prox == MOSTRA);
      // The playback pointer advances between shown notes
      r_contaC      <= (w_prox == PROX_NOTA) || (w_prox == MOSTRA_PROX);
      r_zeraCR      <= (w_prox == PREPARA);
      r_contaCR     <= (w_prox == PROX_RODADA);
      r_registraR   <= (w_prox == TOCA);
      r_leds_mem    <= (w_prox == ESPERA_MOSTRA) || (w_prox == MOSTRA_ULTIMA);
      r_toca        <= (w_prox == TOCA) || (w_prox == ESPERA_MOSTRA) ||
                       (w_prox == MOSTRA_ULTIMA);
      r_vez_jogador <= (w_prox == ESPERA_NOTA);
      r_menu_erro   <= (w_prox == MENU_ERRO);
      r_ganhou      <= (w_prox == GANHOU);
      // ERRO only reports game over when this error consumes the last life
      r_perdeu      <= (w_prox == FIM) || (w_prox == ERRO && r_vidas == 4'd1);
    end
  end

  assign bus.zeraC       = r_zeraC;
  assign bus.contaC      = r_contaC;
  assign bus.zeraCR      = r_zeraCR;
  assign bus.contaCR     = r_contaCR;
  assign bus.registraR   = r_registraR;
  assign bus.leds_mem    = r_leds_mem;
  assign bus.toca        = r_toca;
  assign bus.vez_jogador = r_vez_jogador;
  assign bus.menu_erro   = r_menu_erro;
  assign bus.ganhou      = r_ganhou;
  assign bus.perdeu      = r_perdeu;
  assign bus.vidas       = r_vidas;
  assign bus.pontos      = r_pontos;
  assign bus.db_estado   = r_estado;

endmodule

// File: doc/jogo_controle_vidas.md
JOGO_CONTROLE_VIDAS -- requirements
Module: jogo_controle_vidas

Interface
REQ-001 Parameter VIDAS, default 3, lives per game (1..15).
REQ-002 Parameter TIMEOUT, default 50000, max clock cycles allowed per note in ESPERA_NOTA (>=2).
REQ-003 Parameter PONTOS_W, default 8, score width.
REQ-004 clock  in  1  single system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 iniciar  in  1  start or restart the game.
REQ-007 press_enter  in  1  confirm the error-menu choice.
REQ-008 nota_feita  in  1  player key held.
REQ-009 nota_correta, tempo_correto  in  1 each  compare results, valid in COMPARA.
REQ-010 endereco_igual_rodada  in  1  note pointer equals round index.
REQ-011 fim_rodadas, fim_musica  in  1 each  last round reached; song finished.
REQ-012 fim_mostra  in  1  playback of current note finished.
REQ-013 opcao_erro  in  2  menu choice: 00 repeat round, 01 repeat note, 10 show last note, 11 give up.
REQ-014 zeraC, contaC, zeraCR, contaCR, registraR  out  1 each  datapath strobes.
REQ-015 leds_mem, toca, vez_jogador, menu_erro  out  1 each  display/sound/menu enables.
REQ-016 ganhou, perdeu  out  1 each  game won; game over (lives exhausted or give-up).
REQ-017 vidas  out  4  lives remaining.
REQ-018 pontos  out  PONTOS_W  correct-note score.
REQ-019 db_estado  out  4  current state code.

Function
REQ-020 Moore FSM; state codes: INICIAL=0, PREPARA=1, MOSTRA=2, ESPERA_MOSTRA=3, MOSTRA_PROX=4, INICIO_NOTA=5, ESPERA_NOTA=6, TOCA=7, COMPARA=8, PROX_NOTA=9, PROX_RODADA=A, ERRO=B, MENU_ERRO=C, MOSTRA_ULTIMA=D, GANHOU=E, FIM=F.
REQ-021 INICIAL -> PREPARA when iniciar; PREPARA -> MOSTRA; PREPARA loads vidas=VIDAS, pontos=0, asserts zeraCR and zeraC.
REQ-022 MOSTRA -> ESPERA_MOSTRA; ESPERA_MOSTRA -> (fim_mostra ? (endereco_igual_rodada ? INICIO_NOTA : MOSTRA_PROX) : ESPERA_MOSTRA); MOSTRA_PROX -> MOSTRA.
REQ-023 INICIO_NOTA asserts zeraC, clears the timeout counter, -> ESPERA_NOTA.
REQ-024 ESPERA_NOTA: timeout counter increments each cycle; nota_feita -> TOCA; else counter == TIMEOUT-1 -> ERRO; nota_feita has priority over timeout in the same cycle.
REQ-025 TOCA -> (nota_feita ? TOCA : COMPARA); registraR asserted in TOCA.
REQ-026 COMPARA: !nota_correta or !tempo_correto -> ERRO; else endereco_igual_rodada ? (fim_rodadas or fim_musica ? GANHOU : PROX_RODADA) : PROX_NOTA.
REQ-027 Every COMPARA -> non-ERRO transition increments pontos by 1, saturating at 2^PONTOS_W-1.
REQ-028 PROX_NOTA asserts contaC, clears timeout counter, -> ESPERA_NOTA.
REQ-029 PROX_RODADA asserts contaCR, -> MOSTRA after asserting zeraC.
REQ-030 ERRO decrements vidas once, asserts perdeu only if new vidas == 0; -> FIM if vidas was 1, else MENU_ERRO.
REQ-031 MENU_ERRO holds menu_erro=1 until press_enter; then 00 -> MOSTRA with zeraC, 01 -> INICIO_NOTA, 10 -> MOSTRA_ULTIMA, 11 -> FIM with vidas forced to 0.
REQ-032 MOSTRA_ULTIMA: leds_mem=toca=1; -> INICIO_NOTA on fim_mostra.
REQ-033 GANHOU holds ganhou=1; FIM holds perdeu=1; both -> PREPARA on iniciar.
REQ-034 leds_mem=1 in ESPERA_MOSTRA, MOSTRA_ULTIMA; toca=1 in TOCA, ESPERA_MOSTRA, MOSTRA_ULTIMA; vez_jogador=1 in ESPERA_NOTA only.
REQ-035 Undefined state codes -> INICIAL next cycle.
REQ-036 iniciar is ignored in every state except INICIAL, GANHOU, FIM.

Reset
REQ-037 reset=0 forces state INICIAL, vidas=VIDAS, pontos=0, timeout counter 0, all strobes 0 immediately, independent of clock, including mid-game.
REQ-038 On reset release the FSM leaves INICIAL only on a clock edge with iniciar=1.

Verification
REQ-039 Reset mid-ESPERA_NOTA with pontos=5 -> db_estado=0, pontos=0, vidas=3 before next edge.
REQ-040 Round 0, correct note and tempo, endereco_igual_rodada=1, fim_rodadas=0 -> PROX_RODADA, contaCR pulse 1 cycle, pontos=1.
REQ-041 TIMEOUT=8, no key -> ERRO 8 cycles after entering ESPERA_NOTA, vidas 3->2, MENU_ERRO; opcao 01 + press_enter -> INICIO_NOTA.
REQ-042 nota_feita rises on the cycle counter==TIMEOUT-1 -> TOCA, no life lost.
REQ-043 VIDAS=1, wrong note -> ERRO then FIM, vidas=0, perdeu=1; iniciar -> PREPARA, vidas=1, pontos=0.
REQ-044 PONTOS_W=2, 5 consecutive correct notes -> pontos saturates at 3.
